wb_regfile: RTL and testbench

Writeback-stage register file for the 8-bit pipelined core. It consumes the MEM/WB pipeline outputs (write enable, result, destination, stack push/pop) and commits them to four 8-bit architectural registers, R0-R3. R3 is the stack pointer (SP). The block supplies two combinational read ports with same-cycle write-through to the decode stage, and raises sticky stack fault flags.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/wb_sp_ctrl.sv | 81 ++++++++
 rtl/wb_regfile.sv | 90 +++++++++
 tb/tb_wb_regfile.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and register-index type for the 8-bit pipelined core.
// Fixes the architectural register file geometry and the stack pointer limits.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;

  typedef enum logic [ADDR_W-1:0] {
    REG_R0 = 2'd0,
    REG_R1 = 2'd1,
    REG_R2 = 2'd2,
    REG_R3 = 2'd3
  } reg_idx_e;

  // R3 doubles as the stack pointer.
  localparam reg_idx_e REG_SP = REG_R3;

  localparam logic [ADDR_W-1:0] SP_INDEX = REG_SP;
  localparam logic [DATA_W-1:0] SP_RESET = 8'hFF;
  localparam logic [DATA_W-1:0] SP_LIMIT = 8'h80;

endpackage

// File: rtl/wb_sp_ctrl.sv
// Stack pointer next-value selection for the writeback stage.
// Also generates the sticky overflow/underflow flags and the conflict pulse.
module wb_sp_ctrl
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_reg_write,
  input  logic [ADDR_W-1:0] wb_reg_dist,
  input  logic [DATA_W-1:0] wb_result,
  input  logic              stack_push_wb,
  input  logic              stack_pop_wb,
  input  logic              clr_flags,
  input  logic [DATA_W-1:0] sp_cur,
  output logic [DATA_W-1:0] sp_next,
  output logic              sp_we,
  output logic              stack_ovf,
  output logic              stack_unf,
  output logic              stack_conflict
);

  logic wr_sp_s;
  logic ovf_set_s;
  logic unf_set_s;
  logic conflict_s;
  logic ovf_r;
  logic unf_r;
  logic conflict_r;

  assign wr_sp_s = wb_reg_write && (wb_reg_dist == SP_INDEX);

  // Priority: explicit write, then simultaneous push/pop, then push, then pop.
  always_comb begin
    sp_next    = sp_cur;
    sp_we      = 1'b0;
    ovf_set_s  = 1'b0;
    unf_set_s  = 1'b0;
    conflict_s = 1'b0;
    if (wr_sp_s) begin
      sp_next    = wb_result;
      sp_we      = 1'b1;
      conflict_s = stack_push_wb || stack_pop_wb;
    end else if (stack_push_wb && stack_pop_wb) begin
      conflict_s = 1'b1;
    end else if (stack_push_wb) begin
      if (sp_cur == SP_LIMIT) begin
        ovf_set_s = 1'b1;
      end else begin
        sp_next = sp_cur - DATA_W'(1);
        sp_we   = 1'b1;
      end
    end else if (stack_pop_wb) begin
      if (sp_cur == SP_RESET) begin
        unf_set_s = 1'b1;
      end else begin
        sp_next = sp_cur + DATA_W'(1);
        sp_we   = 1'b1;
      end
    end else begin
      sp_we = 1'b0;
    end
  end

  // Sticky flags: a new fault in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r      <= 1'b0;
      unf_r      <= 1'b0;
      conflict_r <= 1'b0;
    end else begin
      ovf_r      <= ovf_set_s || (ovf_r && !clr_flags);
      unf_r      <= unf_set_s || (unf_r && !clr_flags);
      conflict_r <= conflict_s;
    end
  end

  assign stack_ovf      = ovf_r;
  assign stack_unf      = unf_r;
  assign stack_conflict = conflict_r;

endmodule

// File: rtl/wb_regfile.sv
// Writeback-stage register file: R0-R2 general purpose, R3 stack pointer.
// Two combinational read ports return the post-edge value (write-through).
module wb_regfile
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_reg_write,
  input  logic [DATA_W-1:0] wb_result,
  input  logic [ADDR_W-1:0] wb_reg_dist,
  input  logic              stack_push_wb,
  input  logic              stack_pop_wb,
  input  logic              clr_flags,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] sp_out,
  output logic              stack_ovf,
  output logic              stack_unf,
  output logic              stack_conflict
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_r [NREG];
  logic [DATA_W-1:0] sp_next_s;
  logic              sp_we_s;

  wb_sp_ctrl u_sp_ctrl (
    .clk            (clk),
    .rst            (rst),
    .wb_reg_write   (wb_reg_write),
    .wb_reg_dist    (wb_reg_dist),
    .wb_result      (wb_result),
    .stack_push_wb  (stack_push_wb),
    .stack_pop_wb   (stack_pop_wb),
    .clr_flags      (clr_flags),
    .sp_cur         (regs_r[SP_INDEX]),
    .sp_next        (sp_next_s),
    .sp_we          (sp_we_s),
    .stack_ovf      (stack_ovf),
    .stack_unf      (stack_unf),
    .stack_conflict (stack_conflict)
  );

  // Storage: the SP slot is owned by the stack controller, others by wb_reg_write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        if (ADDR_W'(i) == SP_INDEX) begin
          regs_r[i] <= SP_RESET;
        end else begin
          regs_r[i] <= {DATA_W{1'b0}};
        end
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (ADDR_W'(i) == SP_INDEX) begin
          if (sp_we_s) begin
            regs_r[i] <= sp_next_s;
          end
        end else if (wb_reg_write && (wb_reg_dist == ADDR_W'(i))) begin
          regs_r[i] <= wb_result;
        end
      end
    end
  end

  function automatic logic [DATA_W-1:0] bypass_read(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    if (addr == SP_INDEX) begin
      val = sp_we_s ? sp_next_s : regs_r[SP_INDEX];
    end else if (wb_reg_write && (wb_reg_dist == addr)) begin
      val = wb_result;
    end else begin
      val = regs_r[addr];
    end
    return val;
  endfunction

  // Read ports see the value each register will hold after the current edge.
  always_comb begin
    rd_data_a = bypass_read(rd_addr_a);
    rd_data_b = bypass_read(rd_addr_b);
  end

  assign sp_out = regs_r[SP_INDEX];

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized
// traffic compared against an array-based architectural model.
module tb_wb_regfile;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wb_reg_write = 1'b0;
  logic [7:0] wb_result = 8'h00;
  logic [1:0] wb_reg_dist = 2'd0;
  logic       stack_push_wb = 1'b0;
  logic       stack_pop_wb = 1'b0;
  logic       clr_flags = 1'b0;
  logic [1:0] rd_addr_a = 2'd0;
  logic [1:0] rd_addr_b = 2'd0;
  logic [7:0] rd_data_a;
  logic [7:0] rd_data_b;
  logic [7:0] sp_out;
  logic       stack_ovf;
  logic       stack_unf;
  logic       stack_conflict;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_regs [4];
  logic       m_ovf;
  logic       m_unf;
  logic       m_conf;

  wb_regfile dut (
    .clk            (clk),
    .rst            (rst),
    .wb_reg_write   (wb_reg_write),
    .wb_result      (wb_result),
    .wb_reg_dist    (wb_reg_dist),
    .stack_push_wb  (stack_push_wb),
    .stack_pop_wb   (stack_pop_wb),
    .clr_flags      (clr_flags),
    .rd_addr_a      (rd_addr_a),
    .rd_addr_b      (rd_addr_b),
    .rd_data_a      (rd_data_a),
    .rd_data_b      (rd_data_b),
    .sp_out         (sp_out),
    .stack_ovf      (stack_ovf),
    .stack_unf      (stack_unf),
    .stack_conflict (stack_conflict)
  );

  always #5 clk = ~clk;

  // Model: architectural SP after this cycle's stack request.
  function automatic logic [7:0] m_sp_after();
    logic [7:0] sp = m_regs[3];
    if (wb_reg_write && wb_reg_dist == 2'd3) return wb_result;
    if (stack_push_wb && stack_pop_wb) return sp;
    if (stack_push_wb) return (sp == 8'h80) ? sp : sp - 8'd1;
    if (stack_pop_wb) return (sp == 8'hFF) ? sp : sp + 8'd1;
    return sp;
  endfunction

  function automatic logic [7:0] m_read(input logic [1:0] a);
    if (a == 2'd3) return m_sp_after();
    if (wb_reg_write && wb_reg_dist == a) return wb_result;
    return m_regs[a];
  endfunction

  task automatic m_reset();
    m_regs[0] = 8'h00; m_regs[1] = 8'h00; m_regs[2] = 8'h00; m_regs[3] = 8'hFF;
    m_ovf = 1'b0; m_unf = 1'b0; m_conf = 1'b0;
  endtask

  // Advance one clock edge, updating the model from the inputs presented.
  task automatic cycle();
    logic [7:0] nxt [4];
    logic wr_sp, only_push, only_pop, n_ovf, n_unf, n_conf;
    for (int a = 0; a < 4; a++) nxt[a] = m_read(2'(a));
    wr_sp     = wb_reg_write && wb_reg_dist == 2'd3;
    only_push = !wr_sp && stack_push_wb && !stack_pop_wb;
    only_pop  = !wr_sp && stack_pop_wb && !stack_push_wb;
    n_ovf  = (only_push && m_regs[3] == 8'h80) ? 1'b1 : (clr_flags ? 1'b0 : m_ovf);
    n_unf  = (only_pop && m_regs[3] == 8'hFF) ? 1'b1 : (clr_flags ? 1'b0 : m_unf);
    n_conf = (stack_push_wb && stack_pop_wb) || (wr_sp && (stack_push_wb || stack_pop_wb));
    @(posedge clk);
    for (int a = 0; a < 4; a++) m_regs[a] = nxt[a];
    m_ovf = n_ovf; m_unf = n_unf; m_conf = n_conf;
    #1;
  endtask

  task automatic idle();
    wb_reg_write = 1'b0; stack_push_wb = 1'b0; stack_pop_wb = 1'b0; clr_flags = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk);
    rst = 1'b1;
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    m_reset();
    #3;
    for (int a = 0; a < 4; a++) begin
      rd_addr_a = 2'(a);
      #1;
      checks++;
      if (rd_data_a !== ((a == 3) ? 8'hFF : 8'h00)) begin
        errors++; $display("FAIL reset_reg%0d got %h exp %h", a, rd_data_a, (a == 3) ? 8'hFF : 8'h00);
      end
    end
    checks++;
    if (sp_out !== 8'hFF || {stack_ovf, stack_unf, stack_conflict} !== 3'b000) begin
      errors++; $display("FAIL reset_sp_flags got %h/%b exp ff/000", sp_out, {stack_ovf, stack_unf, stack_conflict});
    end
    @(negedge clk);
    rst = 1'b0;
    cycle();
    wb_reg_write = 1'b1; wb_reg_dist = 2'd1; wb_result = 8'h5A;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle();
    m_reset();
    cycle();
    rd_addr_a = 2'd1;
    #1;
    checks++;
    if (rd_data_a !== 8'h00) begin
      errors++; $display("FAIL reset_midwrite_r1 got %h exp 00", rd_data_a);
    end
  endtask

  task automatic test_bypass_write();
    do_reset();
    wb_reg_write = 1'b1; wb_reg_dist = 2'd1; wb_result = 8'h3C; rd_addr_a = 2'd1; rd_addr_b = 2'd0;
    #1;
    checks++;
    if (rd_data_a !== 8'h3C) begin
      errors++; $display("FAIL bypass_r1_pre got %h exp 3c", rd_data_a);
    end
    cycle();
    idle();
    #1;
    checks++;
    if (rd_data_a !== 8'h3C) begin
      errors++; $display("FAIL bypass_r1_post got %h exp 3c", rd_data_a);
    end
    rd_addr_a = 2'd2;
    #1;
    checks++;
    if (rd_data_a !== 8'h00 || rd_data_b !== 8'h00) begin
      errors++; $display("FAIL bypass_r0_r2 got %h/%h exp 00/00", rd_data_b, rd_data_a);
    end
  endtask

  task automatic test_push_pop();
    logic [7:0] exp_sp [5];
    exp_sp[0] = 8'hFE; exp_sp[1] = 8'hFD; exp_sp[2] = 8'hFC; exp_sp[3] = 8'hFD; exp_sp[4] = 8'hFE;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      stack_push_wb = (i < 3); stack_pop_wb = (i >= 3);
      cycle();
      checks++;
      if (sp_out !== exp_sp[i]) begin
        errors++; $display("FAIL push_pop_step%0d got %h exp %h", i, sp_out, exp_sp[i]);
      end
    end
    stack_push_wb = 1'b1; stack_pop_wb = 1'b0; rd_addr_b = 2'd3;
    #1;
    checks++;
    if (rd_data_b !== 8'hFD) begin
      errors++; $display("FAIL push_bypass_sp got %h exp fd", rd_data_b);
    end
    cycle();
    idle();
  endtask

  task automatic test_underflow();
    do_reset();
    stack_pop_wb = 1'b1;
    cycle();
    idle();
    checks++;
    if (sp_out !== 8'hFF || stack_unf !== 1'b1) begin
      errors++; $display("FAIL unf_set got %h/%b exp ff/1", sp_out, stack_unf);
    end
    cycle();
    checks++;
    if (stack_unf !== 1'b1) begin
      errors++; $display("FAIL unf_sticky got %b exp 1", stack_unf);
    end
    clr_flags = 1'b1;
    cycle();
    idle();
    checks++;
    if (stack_unf !== 1'b0) begin
      errors++; $display("FAIL unf_clear got %b exp 0", stack_unf);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    wb_reg_write = 1'b1; wb_reg_dist = 2'd3; wb_result = 8'h80;
    cycle();
    idle();
    stack_push_wb = 1'b1;
    cycle();
    idle();
    checks++;
    if (sp_out !== 8'h80 || stack_ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_set got %h/%b exp 80/1", sp_out, stack_ovf);
    end
    stack_push_wb = 1'b1; clr_flags = 1'b1;
    cycle();
    idle();
    checks++;
    if (stack_ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_set_beats_clr got %b exp 1", stack_ovf);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    wb_reg_write = 1'b1; wb_reg_dist = 2'd3; wb_result = 8'h90; stack_push_wb = 1'b1;
    cycle();
    idle();
    checks++;
    if (sp_out !== 8'h90 || stack_conflict !== 1'b1) begin
      errors++; $display("FAIL conflict_write got %h/%b exp 90/1", sp_out, stack_conflict);
    end
    wb_reg_write = 1'b1; wb_result = 8'hF0;
    cycle();
    idle();
    checks++;
    if (stack_conflict !== 1'b0) begin
      errors++; $display("FAIL conflict_pulse_end got %b exp 0", stack_conflict);
    end
    stack_push_wb = 1'b1; stack_pop_wb = 1'b1;
    cycle();
    idle();
    checks++;
    if (sp_out !== 8'hF0 || stack_conflict !== 1'b1) begin
      errors++; $display("FAIL conflict_pushpop got %h/%b exp f0/1", sp_out, stack_conflict);
    end
    cycle();
    checks++;
    if (stack_conflict !== 1'b0) begin
      errors++; $display("FAIL conflict_pushpop_end got %b exp 0", stack_conflict);
    end
  endtask

  task automatic test_random();
    logic [7:0] sp_pick [4];
    sp_pick[0] = 8'h80; sp_pick[1] = 8'h81; sp_pick[2] = 8'hFE; sp_pick[3] = 8'hFF;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      wb_reg_write  = ($urandom % 3) == 0;
      wb_reg_dist   = 2'($urandom % 4);
      wb_result     = (wb_reg_dist == 2'd3 && ($urandom % 2) == 0) ? sp_pick[$urandom % 4] : 8'($urandom);
      stack_push_wb = ($urandom % 3) == 0;
      stack_pop_wb  = ($urandom % 3) == 0;
      clr_flags     = ($urandom % 8) == 0;
      rd_addr_a     = 2'($urandom % 4);
      rd_addr_b     = 2'($urandom % 4);
      #1;
      checks++;
      if (rd_data_a !== m_read(rd_addr_a) || rd_data_b !== m_read(rd_addr_b)) begin
        errors++; $display("FAIL rand_read n=%0d got %h/%h exp %h/%h", n, rd_data_a, rd_data_b, m_read(rd_addr_a), m_read(rd_addr_b));
      end
      cycle();
      checks++;
      if (sp_out !== m_regs[3] || stack_ovf !== m_ovf || stack_unf !== m_unf || stack_conflict !== m_conf) begin
        errors++; $display("FAIL rand_state n=%0d got %h %b%b%b exp %h %b%b%b", n, sp_out, stack_ovf, stack_unf, stack_conflict, m_regs[3], m_ovf, m_unf, m_conf);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_bypass_write();
    test_push_pop();
    test_underflow();
    test_overflow();
    test_conflict();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
